// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational add/sub ALU between two requesters. Requests are
//   granted round-robin in IDLE, operands are latched on the handshake, the ALU
//   is driven from those latched operands during EXEC, and the captured result
//   and Negative flag are held in RESP until the granted requester takes them.
//   One operation completes every three cycles at best (IDLE -> EXEC -> RESP).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0_* / req1_*          request channels: valid/ready, operands a/b, sub
//   rsp0_* / rsp1_*          response channels: valid/ready, result, negative
//   alu_data_r1/r2           operands to the ALU (held between operations)
//   alu_control              ALU op select to the ALU (0 add, 1 sub)
//   alu_result/alu_negative  combinational ALU outputs
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_negative,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_negative,

    output logic [WIDTH-1:0] alu_data_r1,
    output logic [WIDTH-1:0] alu_data_r2,
    output logic             alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               gnt_id_q, gnt_id_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sub_q, sub_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               neg_q, neg_d;

    logic               any_valid_c;
    logic               grant_c;
    logic               handshake_c;
    logic               rsp_take_c;

    // Round-robin pick: on contention the requester that did not win last;
    // otherwise whichever one is valid.
    always_comb begin
        any_valid_c = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant_q;
        end else begin
            grant_c = req1_valid;
        end
    end

    // Ready only in IDLE and never during the reset cycle.
    assign req0_ready  = !rst && (state_q == ST_IDLE) && any_valid_c && !grant_c;
    assign req1_ready  = !rst && (state_q == ST_IDLE) && any_valid_c &&  grant_c;
    assign handshake_c = (state_q == ST_IDLE) && any_valid_c;

    // Response consumption is only looked at for the granted requester.
    assign rsp_take_c  = gnt_id_q ? rsp1_ready : rsp0_ready;

    // Next-state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        a_d          = a_q;
        b_d          = b_q;
        sub_d        = sub_q;
        result_d     = result_q;
        neg_d        = neg_q;

        case (state_q)
            ST_IDLE: begin
                if (handshake_c) begin
                    gnt_id_d = grant_c;
                    a_d      = grant_c ? req1_a   : req0_a;
                    b_d      = grant_c ? req1_b   : req0_b;
                    sub_d    = grant_c ? req1_sub : req0_sub;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Grant history only advances once an operation is committed.
                result_d     = alu_result;
                neg_d        = alu_negative;
                last_grant_d = gnt_id_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_take_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gnt_id_q     <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            result_q     <= '0;
            neg_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sub_q        <= sub_d;
            result_q     <= result_d;
            neg_q        <= neg_d;
        end
    end

    // ALU sees the latched operands; they only change on a new handshake.
    assign alu_data_r1   = a_q;
    assign alu_data_r2   = b_q;
    assign alu_control   = sub_q;

    assign rsp0_valid    = (state_q == ST_RESP) && !gnt_id_q;
    assign rsp1_valid    = (state_q == ST_RESP) &&  gnt_id_q;
    assign rsp0_result   = result_q;
    assign rsp1_result   = result_q;
    assign rsp0_negative = neg_q;
    assign rsp1_negative = neg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Bench for alu_arbiter with a behavioural ALU attached to the alu_* ports.
//   Expected results come from plain modulo-2^32 arithmetic; grant order comes
//   from a simple "alternate on contention, req0 first after reset" rule.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp0_valid, rsp0_ready, rsp0_negative;
    logic [W-1:0] rsp0_result;
    logic         rsp1_valid, rsp1_ready, rsp1_negative;
    logic [W-1:0] rsp1_result;
    logic [W-1:0] alu_data_r1, alu_data_r2, alu_result;
    logic         alu_control, alu_negative;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: Negative is reported only for subtraction.
    assign alu_result   = alu_control ? (alu_data_r1 - alu_data_r2) : (alu_data_r1 + alu_data_r2);
    assign alu_negative = alu_control & alu_result[W-1];

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_negative(rsp0_negative),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_negative(rsp1_negative),
        .alu_data_r1(alu_data_r1), .alu_data_r2(alu_data_r2), .alu_control(alu_control),
        .alu_result(alu_result), .alu_negative(alu_negative)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic sub);
        longint unsigned m;
        longint unsigned r;
        m = 64'h1_0000_0000;
        if (sub) r = ({32'b0, a} + m - {32'b0, b}) % m;
        else     r = ({32'b0, a} + {32'b0, b}) % m;
        return r[31:0];
    endfunction

    function automatic logic ref_neg(input logic [31:0] a, input logic [31:0] b, input logic sub);
        return sub && (ref_res(a, b, sub) >= 32'h8000_0000);
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int n);
        return (n == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic rspv(input int n);
        return (n == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    function automatic logic [31:0] rres(input int n);
        return (n == 0) ? rsp0_result : rsp1_result;
    endfunction

    function automatic logic rneg(input int n);
        return (n == 0) ? rsp0_negative : rsp1_negative;
    endfunction

    task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        if (n == 0) begin req0_valid = v; req0_a = a; req0_b = b; req0_sub = s; end
        else        begin req1_valid = v; req1_a = a; req1_b = b; req1_sub = s; end
    endtask

    task automatic set_rsp_ready(input int n, input logic v);
        if (n == 0) rsp0_ready = v;
        else        rsp1_ready = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Runs one operation on requester n; returns what was observed.
    // lat counts clock edges from the accepting edge to the first cycle in
    // which rsp valid is visible (1 => sampled high at the second edge after).
    task automatic do_op(input int n, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, output logic [31:0] res, output logic neg, output int lat,
                         output bit other_seen, output bit unstable, output bit still_valid,
                         output bit timeout);
        int cnt;
        res = '0; neg = 1'b0; lat = 0; other_seen = 0; unstable = 0; still_valid = 0; timeout = 0;
        set_rsp_ready(n, hold == 0);
        set_req(n, 1'b1, a, b, s);
        #1;
        cnt = 0;
        while (!rdy(n) && cnt < 50) begin tick(); cnt++; end
        if (!rdy(n)) begin
            timeout = 1;
            set_req(n, 1'b0, '0, '0, 1'b0);
            return;
        end
        tick();
        set_req(n, 1'b0, '0, '0, 1'b0);
        while (!rspv(n) && lat < 50) begin
            if (rspv(1 - n)) other_seen = 1;
            tick();
            lat++;
        end
        if (!rspv(n)) begin timeout = 1; return; end
        if (rspv(1 - n)) other_seen = 1;
        res = rres(n);
        neg = rneg(n);
        for (int h = 0; h < hold; h++) begin
            tick();
            if (!rspv(n) || rres(n) !== res || rneg(n) !== neg || req0_ready || req1_ready || rspv(1 - n))
                unstable = 1;
        end
        set_rsp_ready(n, 1'b1);
        tick();
        still_valid = rspv(n);
        set_rsp_ready(n, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1'b1, 32'd1, 32'd2, 1'b0);
        set_req(1, 1'b1, 32'd3, 32'd4, 1'b1);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick();
        tick();
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready got %b%b expected 00", req0_ready, req1_ready); end
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++;
            $display("FAIL reset_rsp_valid got %b%b expected 00", rsp0_valid, rsp1_valid); end
        checks++; if (alu_data_r1 !== 32'd0 || alu_data_r2 !== 32'd0 || alu_control !== 1'b0) begin errors++;
            $display("FAIL reset_alu got %h %h %b expected 0 0 0", alu_data_r1, alu_data_r2, alu_control); end
        rst = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL reset_first_grant got %b%b expected 10", req0_ready, req1_ready); end
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] res; logic neg; int lat; bit os, us, sv, to;
        // 5 - 3 on req0
        do_op(0, 32'd5, 32'd3, 1'b1, 0, res, neg, lat, os, us, sv, to);
        checks++; if (to !== 0 || lat !== 1) begin errors++;
            $display("FAIL basic_latency got lat=%0d timeout=%0d expected lat=1 timeout=0", lat, to); end
        checks++; if (res !== 32'd2 || neg !== 1'b0) begin errors++;
            $display("FAIL basic_sub got %h/%b expected 00000002/0", res, neg); end
        checks++; if (os !== 0 || sv !== 0) begin errors++;
            $display("FAIL basic_rsp_only0 got other=%0d still=%0d expected 0 0", os, sv); end
        checks++; if (alu_data_r1 !== 32'd5 || alu_data_r2 !== 32'd3 || alu_control !== 1'b1) begin errors++;
            $display("FAIL alu_hold got %h %h %b expected 5 3 1", alu_data_r1, alu_data_r2, alu_control); end
        // 3 - 5 on req1: negative result
        do_op(1, 32'd3, 32'd5, 1'b1, 0, res, neg, lat, os, us, sv, to);
        checks++; if (to !== 0 || res !== 32'hFFFF_FFFE || neg !== 1'b1 || os !== 0) begin errors++;
            $display("FAIL neg_sub got %h/%b other=%0d to=%0d expected fffffffe/1", res, neg, os, to); end
        // add wraps to zero
        do_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, res, neg, lat, os, us, sv, to);
        checks++; if (to !== 0 || res !== 32'h0 || neg !== 1'b0) begin errors++;
            $display("FAIL add_wrap got %h/%b to=%0d expected 00000000/0", res, neg, to); end
    endtask

    task automatic test_round_robin();
        logic [31:0] a_r [2];
        logic [31:0] b_r [2];
        logic        s_r [2];
        logic [31:0] exp_res;
        logic        exp_neg;
        int          exp_g, model_last, got, cyc, g, rsp_seen;
        bit          hs;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            a_r[i] = $urandom; b_r[i] = $urandom; s_r[i] = 1'($urandom_range(0, 1));
            set_req(i, 1'b1, a_r[i], b_r[i], s_r[i]);
        end
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        model_last = 1; got = 0; cyc = 0; exp_g = 0; rsp_seen = 0;
        exp_res = '0; exp_neg = 1'b0;
        while (got < 8 && cyc < 200) begin
            hs = 0; g = 0;
            if (req0_ready && req1_ready) begin
                checks++; errors++;
                $display("FAIL rr_exclusive both readies high at cycle %0d", cyc);
            end
            if (req0_ready || req1_ready) begin
                g = req1_ready ? 1 : 0;
                checks++; if (g !== 1 - model_last) begin errors++;
                    $display("FAIL rr_order txn %0d got grant %0d expected %0d", got, g, 1 - model_last); end
                exp_g = 1 - model_last;
                exp_res = ref_res(a_r[g], b_r[g], s_r[g]);
                exp_neg = ref_neg(a_r[g], b_r[g], s_r[g]);
                model_last = exp_g;
                got++;
                hs = 1;
            end
            if (rsp0_valid || rsp1_valid) begin
                rsp_seen++;
                checks++; if (rspv(exp_g) !== 1'b1 || rspv(1 - exp_g) !== 1'b0 ||
                              rres(exp_g) !== exp_res || rneg(exp_g) !== exp_neg) begin errors++;
                    $display("FAIL rr_result req%0d got %b%b %h/%b expected %h/%b", exp_g,
                             rsp0_valid, rsp1_valid, rres(exp_g), rneg(exp_g), exp_res, exp_neg); end
            end
            tick();
            cyc++;
            if (hs) begin
                a_r[g] = $urandom; b_r[g] = $urandom; s_r[g] = 1'($urandom_range(0, 1));
                set_req(g, 1'b1, a_r[g], b_r[g], s_r[g]);
            end
        end
        checks++; if (got !== 8) begin errors++;
            $display("FAIL rr_progress got %0d grants expected 8", got); end
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (rsp_seen < 7) begin errors++;
            $display("FAIL rr_responses got %0d expected at least 7", rsp_seen); end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] res; logic neg; int lat; bit os, us, sv, to;
        // Make req1 the last winner so req0 wins the contended grant below.
        do_op(1, 32'd10, 32'd20, 1'b0, 0, res, neg, lat, os, us, sv, to);
        set_req(1, 1'b1, 32'd7, 32'd7, 1'b0);
        do_op(0, 32'h1234_5678, 32'h0000_0078, 1'b1, 4, res, neg, lat, os, us, sv, to);
        set_req(1, 1'b0, '0, '0, 1'b0);
        checks++; if (to !== 0 || res !== 32'h1234_5600 || neg !== 1'b0) begin errors++;
            $display("FAIL stall_result got %h/%b to=%0d expected 12345600/0", res, neg, to); end
        checks++; if (us !== 0) begin errors++;
            $display("FAIL stall_stable got unstable=%0d expected 0", us); end
        checks++; if (sv !== 0 || os !== 0) begin errors++;
            $display("FAIL stall_release got still=%0d other=%0d expected 0 0", sv, os); end
        tick();
    endtask

    task automatic test_reset_exec();
        logic [31:0] res; logic neg; int lat; bit os, us, sv, to;
        int cnt;
        bit bad;
        set_req(0, 1'b1, 32'd100, 32'd1, 1'b0);
        rsp0_ready = 1'b1;
        #1;
        cnt = 0;
        while (!req0_ready && cnt < 20) begin tick(); cnt++; end
        checks++; if (req0_ready !== 1'b1) begin errors++;
            $display("FAIL rexec_accept got ready=%b expected 1", req0_ready); end
        tick();                              // accepted; now in EXEC
        set_req(0, 1'b0, '0, '0, 1'b0);
        set_req(1, 1'b1, 32'd9, 32'd4, 1'b1);
        rst = 1'b1;
        tick();
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rexec_in_reset got rsp=%b%b rdy=%b%b expected 00 00",
                     rsp0_valid, rsp1_valid, req0_ready, req1_ready); end
        rst = 1'b0;
        #1;
        checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++;
            $display("FAIL rexec_idle_grant got %b%b expected 01", req0_ready, req1_ready); end
        set_req(1, 1'b0, '0, '0, 1'b0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (rsp0_valid || rsp1_valid) bad = 1; end
        checks++; if (bad !== 0) begin errors++;
            $display("FAIL rexec_no_rsp got a response after reset expected none"); end
        rsp0_ready = 1'b0;
        do_op(1, 32'd9, 32'd4, 1'b1, 1, res, neg, lat, os, us, sv, to);
        checks++; if (to !== 0 || res !== 32'd5 || neg !== 1'b0 || lat !== 1) begin errors++;
            $display("FAIL rexec_new_op got %h/%b lat=%0d to=%0d expected 00000005/0 lat=1", res, neg, lat, to); end
    endtask

    task automatic test_random();
        logic [31:0] res, a, b; logic neg, s; int lat, n, hold; bit os, us, sv, to;
        for (int i = 0; i < 24; i++) begin
            n = $urandom_range(0, 1);
            a = $urandom; b = $urandom;
            if (i == 0) begin a = 32'h8000_0000; b = 32'd1; end
            if (i == 1) begin a = 32'd0; b = 32'd0; end
            s = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 2);
            do_op(n, a, b, s, hold, res, neg, lat, os, us, sv, to);
            checks++;
            if (to !== 0 || lat !== 1 || res !== ref_res(a, b, s) || neg !== ref_neg(a, b, s) ||
                os !== 0 || us !== 0 || sv !== 0) begin
                errors++;
                $display("FAIL random_op %0d req%0d %h %s %h got %h/%b lat=%0d os=%0d us=%0d sv=%0d to=%0d expected %h/%b",
                         i, n, a, s ? "-" : "+", b, res, neg, lat, os, us, sv, to,
                         ref_res(a, b, s), ref_neg(a, b, s));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_reset_exec();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
